// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: stage enables and clears, PC redirect, syscall halt.
// Define PIPE_HAZARD_PERF_CNT_EN to build the cycle/stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int IM_ADDR_W = 10,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_req_a,
    input  logic [4:0]           id_req_b,
    input  logic                 id_use_a,
    input  logic                 id_use_b,
    input  logic                 ex_r_datamem,
    input  logic                 ex_regfile_w_en,
    input  logic [4:0]           ex_req_w,
    input  logic                 ex_skip_load_use,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jump,
    input  logic [IM_ADDR_W-1:0] ex_pc_guessed,
    input  logic [IM_ADDR_W-1:0] ex_pc_actual,
    input  logic                 ex_halt,
    input  logic                 dm_busy,
    input  logic                 resume,
    output logic                 pc_en,
    output logic                 en_ps1,
    output logic                 en_ps2,
    output logic                 en_ps3,
    output logic                 en_ps4,
    output logic                 clear_ps1,
    output logic                 clear_ps2,
    output logic                 clear_ps3,
    output logic                 clear_ps4,
    output logic                 redirect_valid,
    output logic [IM_ADDR_W-1:0] redirect_pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

    typedef struct packed {
        logic                 pc_en;
        logic [4:1]           en;
        logic [4:1]           clr;
        logic                 rv;
        logic [IM_ADDR_W-1:0] rpc;
        logic                 halted;
    } ctrl_t;

    state_t state, state_next;
    ctrl_t  ctrl;
    logic   mispredict, load_use, hit_a, hit_b;

    assign mispredict = (ex_is_branch | ex_is_jump) & (ex_pc_actual != ex_pc_guessed);
    assign hit_a      = id_use_a & (id_req_a == ex_req_w);
    assign hit_b      = id_use_b & (id_req_b == ex_req_w);
    assign load_use   = ex_r_datamem & ex_regfile_w_en & (ex_req_w != 5'd0) &
                        ~ex_skip_load_use & (hit_a | hit_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_next;
    end

    always_comb begin
        ctrl       = '0;
        state_next = state;
        case (state)
            S_INIT: begin
                ctrl.clr   = 4'b1111;
                state_next = S_RUN;
            end
            S_RUN: begin
                // dm_busy freezes everything; a pending halt or flush is re-seen afterwards
                if (!dm_busy) begin
                    ctrl.pc_en = 1'b1;
                    ctrl.en    = 4'b1111;
                    if (mispredict) begin
                        ctrl.rv     = 1'b1;
                        ctrl.rpc    = ex_pc_actual;
                        ctrl.clr[1] = 1'b1;
                        ctrl.clr[2] = 1'b1;
                    end
                    if (ex_halt) begin
                        // a simultaneous redirect still loads the PC before halting
                        ctrl.pc_en  = mispredict;
                        ctrl.clr[1] = 1'b1;
                        ctrl.clr[2] = 1'b1;
                        state_next  = S_HALT;
                    end else if (!mispredict && load_use) begin
                        ctrl.pc_en  = 1'b0;
                        ctrl.en[1]  = 1'b0;
                        ctrl.clr[2] = 1'b1;
                    end
                end
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
                if (resume) state_next = S_RUN;
            end
            default: begin
                ctrl.clr   = 4'b1111;
                state_next = S_INIT;
            end
        endcase
    end

    assign pc_en          = ctrl.pc_en;
    assign en_ps1         = ctrl.en[1];
    assign en_ps2         = ctrl.en[2];
    assign en_ps3         = ctrl.en[3];
    assign en_ps4         = ctrl.en[4];
    assign clear_ps1      = ctrl.clr[1];
    assign clear_ps2      = ctrl.clr[2];
    assign clear_ps3      = ctrl.clr[3];
    assign clear_ps4      = ctrl.clr[4];
    assign redirect_valid = ctrl.rv;
    assign redirect_pc    = ctrl.rpc;
    assign halted         = ctrl.halted;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic run, stall_ev, flush_ev;
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

    assign run      = (state == S_RUN);
    assign stall_ev = run & (dm_busy | (~mispredict & ~ex_halt & load_use));
    assign flush_ev = run & ~dm_busy & mispredict;

    // counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (run && !(&cyc_q))        cyc_q   <= cyc_q + CNT_W'(1);
            if (stall_ev && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (flush_ev && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control word and counter deltas queued per cycle.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk, rst_n;
    logic [4:0] id_req_a, id_req_b, ex_req_w;
    logic       id_use_a, id_use_b, ex_r_datamem, ex_regfile_w_en, ex_skip_load_use;
    logic       ex_is_branch, ex_is_jump, ex_halt, dm_busy, resume;
    logic [9:0] ex_pc_guessed, ex_pc_actual;
    logic       pc_en, en_ps1, en_ps2, en_ps3, en_ps4;
    logic       clear_ps1, clear_ps2, clear_ps3, clear_ps4, redirect_valid, halted;
    logic [9:0] redirect_pc;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_req_a(id_req_a), .id_req_b(id_req_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_r_datamem(ex_r_datamem), .ex_regfile_w_en(ex_regfile_w_en), .ex_req_w(ex_req_w),
        .ex_skip_load_use(ex_skip_load_use), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_pc_guessed(ex_pc_guessed), .ex_pc_actual(ex_pc_actual), .ex_halt(ex_halt),
        .dm_busy(dm_busy), .resume(resume),
        .pc_en(pc_en), .en_ps1(en_ps1), .en_ps2(en_ps2), .en_ps3(en_ps3), .en_ps4(en_ps4),
        .clear_ps1(clear_ps1), .clear_ps2(clear_ps2), .clear_ps3(clear_ps3), .clear_ps4(clear_ps4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, en1..4, clear1..4, redirect_valid, redirect_pc, halted}
    logic [20:0] ctrl;
    assign ctrl = {pc_en, en_ps1, en_ps2, en_ps3, en_ps4, clear_ps1, clear_ps2, clear_ps3,
                   clear_ps4, redirect_valid, redirect_pc, halted};

    function automatic logic [20:0] mk(bit p, logic [3:0] en, logic [3:0] clr, bit rv,
                                       logic [9:0] rpc, bit h);
        return {p, en, clr, rv, rpc, h};
    endfunction

    localparam logic [20:0] C_INIT = {1'b0, 4'b0000, 4'b1111, 1'b0, 10'd0, 1'b0};
    localparam logic [20:0] C_IDLE = {1'b1, 4'b1111, 4'b0000, 1'b0, 10'd0, 1'b0};
    localparam logic [20:0] C_LU   = {1'b0, 4'b0111, 4'b0100, 1'b0, 10'd0, 1'b0};
    localparam logic [20:0] C_HE   = {1'b0, 4'b1111, 4'b1100, 1'b0, 10'd0, 1'b0};
    localparam logic [20:0] C_HALT = {1'b0, 4'b0000, 4'b0000, 1'b0, 10'd0, 1'b1};
    localparam logic [20:0] C_FRZ  = {1'b0, 4'b0000, 4'b0000, 1'b0, 10'd0, 1'b0};

    typedef struct {
        string       name;
        logic [20:0] ctrl;
        bit          run, stall, flush;
    } exp_t;

    exp_t sb[$];
    int errors = 0, checks = 0;
    logic [31:0] m_cyc = 0, m_stall = 0, m_flush = 0;

    task automatic push(string n, logic [20:0] c, bit r, bit s, bit f);
        exp_t e;
        e.name = n; e.ctrl = c; e.run = r; e.stall = s; e.flush = f;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        id_req_a = 0; id_req_b = 0; id_use_a = 0; id_use_b = 0;
        ex_r_datamem = 0; ex_regfile_w_en = 0; ex_req_w = 0; ex_skip_load_use = 0;
        ex_is_branch = 0; ex_is_jump = 0; ex_pc_guessed = 0; ex_pc_actual = 0;
        ex_halt = 0; dm_busy = 0; resume = 0;
    endtask

    task automatic lu_in(logic [4:0] r);
        ex_r_datamem = 1; ex_regfile_w_en = 1; ex_req_w = r;
    endtask

    task automatic br_in(logic [9:0] g, logic [9:0] a);
        ex_is_branch = 1; ex_pc_guessed = g; ex_pc_actual = a;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_in();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            case (i)
                0, 1: push("rst_held", C_INIT, 0, 0, 0);
                2: begin rst_n = 1'b1; push("rst_release", C_INIT, 0, 0, 0); end
                default: push("run_idle", C_IDLE, 1, 0, 0);
            endcase
            @(negedge clk); e = sb.pop_front();
            if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s ctrl got=%h exp=%h", e.name, ctrl, e.ctrl); end
            checks++;
            if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                errors++;
                $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.name, cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
            checks++;
            if (PERF) begin m_cyc += 32'(e.run); m_stall += 32'(e.stall); m_flush += 32'(e.flush); end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; idle_in();
            case (i)
                0: begin lu_in(5); id_req_a = 5; id_use_a = 1; push("lu_a", C_LU, 1, 1, 0); end
                1: push("lu_bubble", C_IDLE, 1, 0, 0);
                2: begin lu_in(0); id_req_a = 0; id_use_a = 1; push("lu_r0", C_IDLE, 1, 0, 0); end
                3: begin lu_in(5); id_req_a = 5; id_use_a = 1; ex_skip_load_use = 1; push("lu_skip", C_IDLE, 1, 0, 0); end
                4: begin lu_in(12); id_req_b = 12; id_use_b = 1; push("lu_b", C_LU, 1, 1, 0); end
                5: begin lu_in(12); id_req_a = 12; push("lu_nouse", C_IDLE, 1, 0, 0); end
                default: begin lu_in(7); ex_r_datamem = 0; id_req_a = 7; id_use_a = 1; push("lu_noload", C_IDLE, 1, 0, 0); end
            endcase
            @(negedge clk); e = sb.pop_front();
            if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s ctrl got=%h exp=%h", e.name, ctrl, e.ctrl); end
            checks++;
            if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                errors++;
                $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.name, cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
            checks++;
            if (PERF) begin m_cyc += 32'(e.run); m_stall += 32'(e.stall); m_flush += 32'(e.flush); end
        end
    endtask

    task automatic test_mispredict();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; idle_in();
            case (i)
                0: begin br_in(10'h040, 10'h080); push("br_miss", mk(1, 4'hF, 4'hC, 1, 10'h080, 0), 1, 0, 1); end
                1: begin br_in(10'h080, 10'h080); push("br_hit", C_IDLE, 1, 0, 0); end
                2: begin ex_is_jump = 1; ex_pc_guessed = 0; ex_pc_actual = 10'h3FF;
                         push("jmp_miss", mk(1, 4'hF, 4'hC, 1, 10'h3FF, 0), 1, 0, 1); end
                3: begin ex_pc_guessed = 10'h011; ex_pc_actual = 10'h222; push("no_br", C_IDLE, 1, 0, 0); end
                4: begin br_in(10'h100, 10'h155); lu_in(9); id_req_a = 9; id_use_a = 1;
                         push("miss_over_lu", mk(1, 4'hF, 4'hC, 1, 10'h155, 0), 1, 0, 1); end
                default: push("post_flush", C_IDLE, 1, 0, 0);
            endcase
            @(negedge clk); e = sb.pop_front();
            if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s ctrl got=%h exp=%h", e.name, ctrl, e.ctrl); end
            checks++;
            if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                errors++;
                $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.name, cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
            checks++;
            if (PERF) begin m_cyc += 32'(e.run); m_stall += 32'(e.stall); m_flush += 32'(e.flush); end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; idle_in();
            case (i)
                0: begin ex_halt = 1; lu_in(3); id_req_a = 3; id_use_a = 1; push("halt_entry", C_HE, 1, 0, 0); end
                3: begin dm_busy = 1; br_in(10'h001, 10'h002); push("halt_ignores", C_HALT, 0, 0, 0); end
                6: begin resume = 1; dm_busy = 1; ex_halt = 1; push("halt_resume", C_HALT, 0, 0, 0); end
                7: push("halt_back_run", C_IDLE, 1, 0, 0);
                default: push("halt_hold", C_HALT, 0, 0, 0);
            endcase
            @(negedge clk); e = sb.pop_front();
            if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s ctrl got=%h exp=%h", e.name, ctrl, e.ctrl); end
            checks++;
            if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                errors++;
                $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.name, cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
            checks++;
            if (PERF) begin m_cyc += 32'(e.run); m_stall += 32'(e.stall); m_flush += 32'(e.flush); end
        end
    endtask

    task automatic test_busy_combo();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; idle_in();
            case (i)
                0, 1, 2: begin dm_busy = 1; ex_halt = 1; br_in(10'h040, 10'h123); push("busy_freeze", C_FRZ, 1, 1, 0); end
                3: begin ex_halt = 1; br_in(10'h040, 10'h123); push("busy_release", mk(1, 4'hF, 4'hC, 1, 10'h123, 0), 1, 0, 1); end
                4: push("busy_halted", C_HALT, 0, 0, 0);
                5: begin resume = 1; push("busy_resume", C_HALT, 0, 0, 0); end
                default: begin dm_busy = 1; lu_in(4); id_req_a = 4; id_use_a = 1; push("busy_over_lu", C_FRZ, 1, 1, 0); end
            endcase
            @(negedge clk); e = sb.pop_front();
            if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s ctrl got=%h exp=%h", e.name, ctrl, e.ctrl); end
            checks++;
            if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                errors++;
                $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.name, cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
            checks++;
            if (PERF) begin m_cyc += 32'(e.run); m_stall += 32'(e.stall); m_flush += 32'(e.flush); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; idle_in();
            case (i)
                0: begin ex_halt = 1; push("mid_halt_entry", C_HE, 1, 0, 0); end
                1: push("mid_halted", C_HALT, 0, 0, 0);
                2: begin rst_n = 1'b0; m_cyc = 0; m_stall = 0; m_flush = 0; push("mid_rst_async", C_INIT, 0, 0, 0); end
                3: push("mid_rst_held", C_INIT, 0, 0, 0);
                4: begin rst_n = 1'b1; push("mid_rst_release", C_INIT, 0, 0, 0); end
                default: push("mid_run", C_IDLE, 1, 0, 0);
            endcase
            @(negedge clk); e = sb.pop_front();
            if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s ctrl got=%h exp=%h", e.name, ctrl, e.ctrl); end
            checks++;
            if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                errors++;
                $display("FAIL %s cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.name, cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
            checks++;
            if (PERF) begin m_cyc += 32'(e.run); m_stall += 32'(e.stall); m_flush += 32'(e.flush); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_halt();
        test_busy_combo();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and flush controller that drives the `en` / `clear` inputs of the four pipeline stage registers (PS1 IF/ID, PS2 ID/EX, PS3 EX/MEM, PS4 MEM/WB) and the PC enable.
- Detects load-use hazards, branch/jump mispredictions resolved in EX, data-memory wait states and syscall halt.
- Emits the PC redirect target and optional performance counters.

Parameters:
- IM_ADDR_W, 10, width of PC / instruction-memory word address (matches `IM_ADDR_BIT`).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_req_a  in  5  ID-stage source register A
- id_req_b  in  5  ID-stage source register B
- id_use_a  in  1  ID instruction reads A
- id_use_b  in  1  ID instruction reads B
- ex_r_datamem  in  1  EX instruction is a load
- ex_regfile_w_en  in  1  EX instruction writes the register file
- ex_req_w  in  5  EX destination register
- ex_skip_load_use  in  1  EX load already forwarded; suppress the stall
- ex_is_branch  in  1  EX holds a branch
- ex_is_jump  in  1  EX holds a jump
- ex_pc_guessed  in  IM_ADDR_W  predicted next PC carried with the EX instruction
- ex_pc_actual  in  IM_ADDR_W  resolved next PC
- ex_halt  in  1  EX syscall requests halt
- dm_busy  in  1  data memory not ready this cycle
- resume  in  1  leave HALT
- pc_en  out  1  PC register enable
- en_ps1..en_ps4  out  1 each  stage register enables
- clear_ps1..clear_ps4  out  1 each  stage register synchronous clears (clear beats en inside the stage)
- redirect_valid  out  1  PC must load redirect_pc
- redirect_pc  out  IM_ADDR_W  corrected PC
- halted  out  1  FSM in HALT
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- FSM states:
  - INIT: held while rst_n is low and for 1 cycle after release. All clear_ps* = 1, all en = 0, pc_en = 0, redirect_valid = 0. Goes to RUN.
  - RUN: per-cycle priority list below.
  - HALT: all en = 0, all clear = 0, pc_en = 0, halted = 1. `resume` moves to RUN next edge; during HALT, `resume` beats every other input.
- Control outputs are combinational from inputs and state, so they take effect in the same cycle. FSM and counters are registered.
- RUN priority, highest first:
  - (a) dm_busy = 1: all en = 0, all clear = 0, pc_en = 0. A freeze that masks b–d, including ex_halt, which is re-evaluated after the freeze.
  - (b) Mispredict = (ex_is_branch | ex_is_jump) & (ex_pc_actual != ex_pc_guessed):
    - redirect_valid = 1, redirect_pc = ex_pc_actual, pc_en = 1.
    - clear_ps1 = clear_ps2 = 1; en_ps3 = en_ps4 = 1.
    - Overrides load-use.
  - (c) ex_halt: en_ps3 = en_ps4 = 1 (the syscall drains); clear_ps1 = clear_ps2 = 1; pc_en = 0. Next state HALT. If mispredict is also true, (b) is applied in the same cycle and the FSM still enters HALT.
  - (d) Load-use = ex_r_datamem & ex_regfile_w_en & (ex_req_w != 0) & !ex_skip_load_use & ((id_use_a & id_req_a == ex_req_w) | (id_use_b & id_req_b == ex_req_w)):
    - pc_en = 0, en_ps1 = 0, clear_ps2 = 1 (bubble), en_ps3 = en_ps4 = 1.
    - Lasts exactly 1 cycle, because the bubble clears the EX condition.
  - (e) Otherwise: all en = 1, all clear = 0, pc_en = 1.
- redirect_pc is 0 whenever redirect_valid = 0.
- Counters:
  - Reset to 0; saturate at all-ones.
  - cycle_cnt increments every cycle in RUN.
  - stall_cnt increments on (a) or (d).
  - flush_cnt increments on (b).
- Reset mid-operation forces INIT asynchronously; counters clear and halted = 0.

Optional Feature:
- PIPE_HAZARD_PERF_CNT_EN:
  - Defined: the three counters are implemented as above.
  - Undefined: counter registers are omitted and cycle_cnt / stall_cnt / flush_cnt are tied to 0. Control behaviour is identical.

Test Plan:
- Reset release → 1 cycle with clear_ps1..4 = 1 and pc_en = 0, then RUN with all en = 1; counters 0.
- ex_r_datamem = 1, ex_regfile_w_en = 1, ex_req_w = 5, id_req_a = 5, id_use_a = 1 → 1 cycle of pc_en = 0, en_ps1 = 0, clear_ps2 = 1, stall_cnt += 1. Repeat with ex_req_w = 0 or ex_skip_load_use = 1 → no stall.
- ex_is_branch = 1, ex_pc_guessed = 0x040, ex_pc_actual = 0x080 → redirect_valid = 1, redirect_pc = 0x080, clear_ps1 = clear_ps2 = 1, flush_cnt = 1. Same case with actual = guessed → no flush.
- Mispredict and load-use in the same cycle → flush only; pc_en = 1; stall_cnt unchanged.
- ex_halt = 1 → HALT next cycle, halted = 1, all en = 0 for 5 cycles. resume pulse → RUN; cycle_cnt did not advance while halted.
- dm_busy held for 3 cycles concurrently with ex_halt and a mispredict → 3 freeze cycles (all en = 0, stall_cnt += 3), then the flush and HALT entry happen on cycle 4.
